// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline package: memory-port request/response structs and the
// response-state encoding used by mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } rsp_state_e;

    // Stage-register view of one request presented to the RAM port
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one synchronous single-port RAM.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win over load/store.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    rsp_state_e                 rsp_st_q, rsp_st_d;
    logic [MEM_ARB_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic                       starve_hit;
    logic                       fetch_priority;
    mem_req_t                   sel;

    // Grants are gated by reset_n so nothing reaches the RAM while held in reset
    always_comb begin
        starve_hit     = (int'(starve_cnt_q) >= STARVE_LIMIT);
        fetch_priority = GUARD_EN && if_req && starve_hit;
        ls_gnt         = reset_n && ls_req && !fetch_priority;
        if_gnt         = reset_n && if_req && !ls_gnt;

        sel = '0;
        if (ls_gnt) begin
            sel = '{req: 1'b1, we: ls_we, addr: ls_addr, wdata: ls_wdata};
        end else if (if_gnt) begin
            sel = '{req: 1'b1, we: 1'b0, addr: if_addr, wdata: 32'h0};
        end

        rsp_st_d = IDLE;
        if (ls_gnt) begin
            rsp_st_d = ls_we ? LS_WR : LS_RD;
        end else if (if_gnt) begin
            rsp_st_d = IF_RD;
        end

        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (ls_gnt && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    assign ram_en    = sel.req;
    assign ram_we    = sel.we;
    assign ram_addr  = sel.addr;
    assign ram_wdata = sel.wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_st_q     <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            rsp_st_q     <= rsp_st_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response routing depends only on the registered state
    assign if_rvalid = (rsp_st_q == IF_RD);
    assign ls_rvalid = (rsp_st_q == LS_RD);
    assign if_rdata  = if_rvalid ? ram_rdata : 32'h0;
    assign ls_rdata  = ls_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM, word addressed by byte address [9:2]
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        lsr;
        logic        lswe;
        logic [31:0] lsa;
        logic [31:0] lswd;
        logic        e_ifg;
        logic        e_lsg;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_lsv;
        logic [31:0] e_lsd;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic lsr,
                         input logic lswe, input logic [31:0] lsa, input logic [31:0] lswd);
        if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = lswe; ls_addr = lsa; ls_wdata = lswd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_gnt"},    {31'h0, if_gnt},    32'h0);
        chk({tag, ".ls_gnt"},    {31'h0, ls_gnt},    32'h0);
        chk({tag, ".ram_en"},    {31'h0, ram_en},    32'h0);
        chk({tag, ".ram_we"},    {31'h0, ram_we},    32'h0);
        chk({tag, ".ram_addr"},  ram_addr,           32'h0);
        chk({tag, ".ram_wdata"}, ram_wdata,          32'h0);
        chk({tag, ".if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
        chk({tag, ".ls_rvalid"}, {31'h0, ls_rvalid}, 32'h0);
        chk({tag, ".if_rdata"},  if_rdata,           32'h0);
        chk({tag, ".ls_rdata"},  ls_rdata,           32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i * 4);
        mem[4] = 32'hDEAD_BEEF;

        //            ifr ifa      lsr we lsa     lswd          ifg lsg en we addr    wd            ifv ifd           lsv lsd
        vecs[0]  = '{1, 32'h10, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h10, 32'h0,        0, 32'h0,         0, 32'h0};
        vecs[1]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        1, 32'hDEADBEEF,  0, 32'h0};
        vecs[2]  = '{1, 32'h0,  1, 0, 32'h40, 32'h0,        0, 1, 1, 0, 32'h40, 32'h0,        0, 32'h0,         0, 32'h0};
        vecs[3]  = '{1, 32'h0,  0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0,         1, 32'h10000040};
        vecs[4]  = '{0, 32'h0,  1, 1, 32'h20, 32'h12345678, 0, 1, 1, 1, 32'h20, 32'h12345678, 1, 32'h10000000,  0, 32'h0};
        vecs[5]  = '{1, 32'h20, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h20, 32'h0,        0, 32'h0,         0, 32'h0};
        vecs[6]  = '{1, 32'h0,  0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h0,  32'h0,        1, 32'h12345678,  0, 32'h0};
        vecs[7]  = '{1, 32'h4,  0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h4,  32'h0,        1, 32'h10000000,  0, 32'h0};
        vecs[8]  = '{1, 32'h8,  0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h8,  32'h0,        1, 32'h10000004,  0, 32'h0};
        vecs[9]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        1, 32'h10000008,  0, 32'h0};
        vecs[10] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,         0, 32'h0};

        // Reset: requests asserted but everything must stay quiet
        reset_n = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF);
        #12;
        chk_all_zero("reset");
        $display("reset state checked");

        @(negedge clk);
        reset_n = 1'b1;
        for (int v = 0; v <= 10; v++) begin
            drive(vecs[v].ifr, vecs[v].ifa, vecs[v].lsr, vecs[v].lswe, vecs[v].lsa, vecs[v].lswd);
            #2;
            chk($sformatf("v%0d.if_gnt", v),    {31'h0, if_gnt},    {31'h0, vecs[v].e_ifg});
            chk($sformatf("v%0d.ls_gnt", v),    {31'h0, ls_gnt},    {31'h0, vecs[v].e_lsg});
            chk($sformatf("v%0d.ram_en", v),    {31'h0, ram_en},    {31'h0, vecs[v].e_en});
            chk($sformatf("v%0d.ram_we", v),    {31'h0, ram_we},    {31'h0, vecs[v].e_we});
            chk($sformatf("v%0d.ram_addr", v),  ram_addr,           vecs[v].e_addr);
            chk($sformatf("v%0d.ram_wdata", v), ram_wdata,          vecs[v].e_wd);
            chk($sformatf("v%0d.if_rvalid", v), {31'h0, if_rvalid}, {31'h0, vecs[v].e_ifv});
            chk($sformatf("v%0d.if_rdata", v),  if_rdata,           vecs[v].e_ifd);
            chk($sformatf("v%0d.ls_rvalid", v), {31'h0, ls_rvalid}, {31'h0, vecs[v].e_lsv});
            chk($sformatf("v%0d.ls_rdata", v),  ls_rdata,           vecs[v].e_lsd);
            $display("vec %0d: if_gnt=%0b ls_gnt=%0b ram_addr=0x%08h if_rvalid=%0b ls_rvalid=%0b",
                     v, if_gnt, ls_gnt, ram_addr, if_rvalid, ls_rvalid);
            @(negedge clk);
        end

        // Starvation: both sides request continuously; counter starts cleared
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 10; k++) begin
            logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = ((k % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            #2;
            chk($sformatf("starve%0d.if_gnt", k), {31'h0, if_gnt}, {31'h0, exp_if});
            chk($sformatf("starve%0d.ls_gnt", k), {31'h0, ls_gnt}, {31'h0, ~exp_if});
            $display("starve cycle %0d: if_gnt=%0b ls_gnt=%0b", k, if_gnt, ls_gnt);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset pulsed during a fetch-grant cycle, held across the edge
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_mid.if_gnt_before", {31'h0, if_gnt}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid.low");
        @(posedge clk);
        #1;
        chk_all_zero("rst_mid.edge");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_mid.if_rvalid_rel0", {31'h0, if_rvalid}, 32'h0);
        @(negedge clk);
        #2;
        chk("rst_mid.if_rvalid_rel1", {31'h0, if_rvalid}, 32'h0);
        $display("reset mid-read sequence checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive load/store grants while fetch waits (range 1..15).
REQ-002 Port: clk  input  1  clock, all state on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: if_req in 1 fetch request; if_addr in 32 fetch byte address; if_gnt out 1 fetch accepted this cycle.
REQ-005 Ports: if_rvalid out 1 fetch data valid; if_rdata out 32 fetched word.
REQ-006 Ports: ls_req in 1 load/store request; ls_we in 1 1=store; ls_addr in 32; ls_wdata in 32; ls_gnt out 1 accepted this cycle.
REQ-007 Ports: ls_rvalid out 1 load data valid; ls_rdata out 32 loaded word.
REQ-008 Ports: ram_en out 1; ram_we out 1; ram_addr out 32; ram_wdata out 32; ram_rdata in 32, valid one cycle after a read enable.

Function
REQ-009 The block SHALL share one synchronous single-port RAM between fetch and load/store; at most one grant per cycle.
REQ-010 Grant SHALL be combinational in the request cycle; a request is accepted when req=1 and gnt=1, and the requester holds req/addr/wdata stable until gnt.
REQ-011 Default priority: ls_req SHALL win over if_req when both are asserted.
REQ-012 ram_en SHALL equal if_gnt|ls_gnt; ram_addr/ram_we/ram_wdata SHALL come from the granted requester; ram_we=0 for fetch; ram_addr=0, ram_wdata=0, ram_we=0 when idle.
REQ-013 Response state machine, register rsp_st, states IDLE, IF_RD, LS_RD, LS_WR: next state IF_RD on fetch grant, LS_RD on load grant, LS_WR on store grant, IDLE when no grant; grants SHALL be accepted back-to-back in every state.
REQ-014 if_rvalid SHALL be 1 exactly in the cycle after a fetch grant (rsp_st==IF_RD), and ls_rvalid exactly in the cycle after a load grant (rsp_st==LS_RD); latency 1 cycle, fixed.
REQ-015 if_rdata and ls_rdata SHALL equal ram_rdata when the matching rvalid=1, else 0.
REQ-016 Stores SHALL produce no rvalid; LS_WR lasts one cycle.
REQ-017 Starvation counter starve_cnt (4 bits): increments on each ls grant while if_req=1; clears on any fetch grant or when if_req=0; saturates at 15.
REQ-018 Simultaneous req on both in the same cycle as a response SHALL not delay the response; response routing depends only on rsp_st.

Reset
REQ-019 Asserting reset_n low SHALL asynchronously force rsp_st=IDLE, starve_cnt=0, all rvalid/rdata=0; grant and ram outputs SHALL be 0 while reset_n=0.
REQ-020 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after release.
REQ-021 First grant possible in the first clock edge cycle after reset_n deasserts.

Configuration
REQ-022 Macro MEM_ARB_STARVE_GUARD_EN: when defined, if starve_cnt>=STARVE_LIMIT and if_req=1, fetch SHALL win over ls_req for that cycle, clearing starve_cnt.
REQ-023 Without MEM_ARB_STARVE_GUARD_EN: strict load/store priority always; starve_cnt remains implemented for debug visibility only and SHALL NOT affect grants.

Structure
REQ-024 Enum rsp_state_e (IDLE, IF_RD, LS_RD, LS_WR) and constant MEM_ARB_CNT_W=4 SHALL live in the shared pipeline package beside the stage-register structs.
REQ-025 Single module, no sub-modules; the grant decode is one combinational block, the state and counter one always_ff.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x10, RAM[0x10]=0xDEADBEEF -> if_gnt=1 same cycle, next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-027 Conflict: if_req=ls_req=1, ls_we=0, ls_addr=0x40 -> ls_gnt=1, if_gnt=0; next cycle ls_rvalid=1 and ls_rdata=RAM[0x40]; fetch granted once ls_req drops.
REQ-028 Store: ls_req=1, ls_we=1, ls_addr=0x20, ls_wdata=0x12345678 -> ram_we=1, no rvalid next cycle; a following fetch of 0x20 returns 0x12345678.
REQ-029 Starvation (macro defined, STARVE_LIMIT=4): both requesting continuously -> grant pattern LS,LS,LS,LS,IF repeating; macro undefined -> IF never granted.
REQ-030 Reset mid-read: fetch granted, reset_n pulsed low before next edge -> if_rvalid=0 throughout and after release, all outputs 0 during reset.
REQ-031 Back-to-back: fetch 0x0,0x4,0x8 on consecutive cycles -> if_rvalid=1 on three consecutive cycles with words in order.
